// File: rtl/tca_obi_xbar_demux.sv
// tca_obi_xbar_demux
// 1-to-N data-bus demultiplexer between the core LSU port and the system
// targets. Table-driven address decode, in-order response routing guarded by
// an outstanding-transaction counter, a small internal MMIO target
// (exit / print / 64-bit cycle counter) and an error target for unmapped
// addresses.
//
// Handshake: a request is transferred on a cycle where core_req_i and
// core_gnt_o are both high (accept). Every accepted request gets exactly one
// response, signalled by a single-cycle core_rvalid_o with core_rdata_o and
// core_err_o valid in that same cycle, in request order. Responses may be
// retired and a new request accepted in the same cycle.
module tca_obi_xbar_demux #(
    parameter int unsigned               N_SLV     = 4,
    parameter int unsigned               MAX_OUTST = 4,
    parameter logic [N_SLV-1:0][31:0]    SLV_BASE  = '0,
    parameter logic [N_SLV-1:0][31:0]    SLV_MASK  = '0,
    parameter logic [31:0]               MMIO_BASE = 32'h8000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    // core side
    input  logic                     core_req_i,
    output logic                     core_gnt_o,
    input  logic [31:0]              core_addr_i,
    input  logic                     core_we_i,
    input  logic [3:0]               core_be_i,
    input  logic [31:0]              core_wdata_i,
    output logic                     core_rvalid_o,
    output logic [31:0]              core_rdata_o,
    output logic                     core_err_o,
    // target side
    output logic [N_SLV-1:0]         slv_req_o,
    input  logic [N_SLV-1:0]         slv_gnt_i,
    output logic [31:0]              slv_addr_o,
    output logic                     slv_we_o,
    output logic [3:0]               slv_be_o,
    output logic [31:0]              slv_wdata_o,
    input  logic [N_SLV-1:0]         slv_rvalid_i,
    input  logic [N_SLV-1:0][31:0]   slv_rdata_i,
    // MMIO side effects
    output logic                     exit_valid_o,
    output logic [31:0]              exit_code_o,
    output logic                     print_valid_o,
    output logic [7:0]               print_char_o
);

    localparam int unsigned TGT_W = $clog2(N_SLV + 2);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    // Target encoding: 0..N_SLV-1 external, then the two internal targets.
    localparam logic [TGT_W-1:0] TGT_MMIO = TGT_W'(N_SLV);
    localparam logic [TGT_W-1:0] TGT_ERR  = TGT_W'(N_SLV + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);

    logic [TGT_W-1:0] tgt;
    logic             tgt_int;
    logic             tgt_gnt;
    logic             allowed;
    logic             accept;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_eff;
    logic [TGT_W-1:0] cur_tgt_q;

    logic             sel_rvalid;
    logic [31:0]      sel_rdata;
    logic             sel_err;
    logic             resp_fire;

    logic             int_rvalid_q;
    logic             int_err_q;
    logic [31:0]      int_rdata_q;
    logic [31:0]      mmio_rdata;

    logic [63:0]      cycle_q;
    logic [31:0]      exit_code_q;
    logic [7:0]       print_char_q;

    // Address decode: MMIO window first, then the lowest matching table entry.
    always_comb begin
        tgt = TGT_ERR;
        if (core_addr_i[31:4] == MMIO_BASE[31:4]) begin
            tgt = TGT_MMIO;
        end else begin
            for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
                if ((core_addr_i & SLV_MASK[i]) == SLV_BASE[i]) begin
                    tgt = TGT_W'(i);
                end
            end
        end
    end

    assign tgt_int = (tgt == TGT_MMIO) || (tgt == TGT_ERR);

    // Pick the response source belonging to the target that owns the
    // outstanding transactions; everything else is ignored.
    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        sel_err    = 1'b0;
        if ((cur_tgt_q == TGT_MMIO) || (cur_tgt_q == TGT_ERR)) begin
            sel_rvalid = int_rvalid_q;
            sel_rdata  = int_rdata_q;
            sel_err    = int_err_q;
        end else begin
            for (int i = 0; i < int'(N_SLV); i++) begin
                if (cur_tgt_q == TGT_W'(i)) begin
                    sel_rvalid = slv_rvalid_i[i];
                    sel_rdata  = slv_rdata_i[i];
                end
            end
        end
    end

    // A response with nothing outstanding is dropped so the count cannot wrap.
    assign resp_fire = sel_rvalid && (cnt_q != '0);

    // Outstanding count after retiring this cycle's response; lets a stalled
    // request to a new target go out in the same cycle the last response returns.
    assign cnt_eff = cnt_q - CNT_W'(resp_fire);

    assign allowed = rst_ni && core_req_i && (cnt_eff < CNT_MAX) &&
                     ((cnt_eff == '0) || (tgt == cur_tgt_q));

    // Route the request to the decoded target and pick its grant.
    always_comb begin
        slv_req_o = '0;
        tgt_gnt   = tgt_int;
        for (int i = 0; i < int'(N_SLV); i++) begin
            if (tgt == TGT_W'(i)) begin
                slv_req_o[i] = allowed;
                tgt_gnt      = slv_gnt_i[i];
            end
        end
    end

    assign core_gnt_o = allowed && tgt_gnt;
    assign accept     = core_gnt_o;

    // Broadcast request fields, held at zero while in reset.
    assign slv_addr_o  = rst_ni ? core_addr_i  : '0;
    assign slv_we_o    = rst_ni && core_we_i;
    assign slv_be_o    = rst_ni ? core_be_i    : '0;
    assign slv_wdata_o = rst_ni ? core_wdata_i : '0;

    assign core_rvalid_o = resp_fire;
    assign core_rdata_o  = resp_fire ? sel_rdata : '0;
    assign core_err_o    = resp_fire && sel_err;

    // MMIO side effects fire combinationally on the accept cycle.
    assign exit_valid_o  = accept && (tgt == TGT_MMIO) && core_we_i &&
                           (core_addr_i[3:2] == 2'b00);
    assign print_valid_o = accept && (tgt == TGT_MMIO) && core_we_i &&
                           (core_addr_i[3:2] == 2'b01);
    assign exit_code_o   = exit_valid_o  ? core_wdata_i      : exit_code_q;
    assign print_char_o  = print_valid_o ? core_wdata_i[7:0] : print_char_q;

    // MMIO read data, sampled on the accept cycle.
    always_comb begin
        mmio_rdata = '0;
        case (core_addr_i[3:2])
            2'b00:   mmio_rdata = cycle_q[31:0];
            2'b10:   mmio_rdata = cycle_q[63:32];
            default: mmio_rdata = '0;
        endcase
    end

    // Outstanding counter and owner of the outstanding transactions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            cur_tgt_q <= '0;
        end else begin
            cnt_q <= cnt_eff + CNT_W'(accept);
            if (accept) begin
                cur_tgt_q <= tgt;
            end
        end
    end

    // Internal MMIO/ERR responder: answers exactly one cycle after accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            int_rvalid_q <= 1'b0;
            int_err_q    <= 1'b0;
            int_rdata_q  <= '0;
        end else begin
            int_rvalid_q <= accept && tgt_int;
            int_err_q    <= accept && (tgt == TGT_ERR);
            int_rdata_q  <= (accept && (tgt == TGT_MMIO) && !core_we_i) ? mmio_rdata : '0;
        end
    end

    // Free-running cycle counter and held MMIO write values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q      <= '0;
            exit_code_q  <= '0;
            print_char_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (exit_valid_o) begin
                exit_code_q <= core_wdata_i;
            end
            if (print_valid_o) begin
                print_char_q <= core_wdata_i[7:0];
            end
        end
    end

endmodule

// File: tb/tb_tca_obi_xbar_demux.sv
// Directed testbench for tca_obi_xbar_demux. Targets: slave i lives at
// 0x(i+1)000_0000 with a 256 MB mask; MMIO at 0x8000_0000.
module tb_tca_obi_xbar_demux;

    localparam int unsigned N_SLV = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   core_req;
    logic                   core_gnt;
    logic [31:0]            core_addr;
    logic                   core_we;
    logic [3:0]             core_be;
    logic [31:0]            core_wdata;
    logic                   core_rvalid;
    logic [31:0]            core_rdata;
    logic                   core_err;
    logic [N_SLV-1:0]       slv_req;
    logic [N_SLV-1:0]       slv_gnt;
    logic [31:0]            slv_addr;
    logic                   slv_we;
    logic [3:0]             slv_be;
    logic [31:0]            slv_wdata;
    logic [N_SLV-1:0]       slv_rvalid;
    logic [N_SLV-1:0][31:0] slv_rdata;
    logic                   exit_valid;
    logic [31:0]            exit_code;
    logic                   print_valid;
    logic [7:0]             print_char;

    int n_tests = 0;
    int n_fail  = 0;

    tca_obi_xbar_demux #(
        .N_SLV     (N_SLV),
        .MAX_OUTST (4),
        .SLV_BASE  ({32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
        .SLV_MASK  ({4{32'hF000_0000}}),
        .MMIO_BASE (32'h8000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .core_req_i    (core_req),
        .core_gnt_o    (core_gnt),
        .core_addr_i   (core_addr),
        .core_we_i     (core_we),
        .core_be_i     (core_be),
        .core_wdata_i  (core_wdata),
        .core_rvalid_o (core_rvalid),
        .core_rdata_o  (core_rdata),
        .core_err_o    (core_err),
        .slv_req_o     (slv_req),
        .slv_gnt_i     (slv_gnt),
        .slv_addr_o    (slv_addr),
        .slv_we_o      (slv_we),
        .slv_be_o      (slv_be),
        .slv_wdata_o   (slv_wdata),
        .slv_rvalid_i  (slv_rvalid),
        .slv_rdata_i   (slv_rdata),
        .exit_valid_o  (exit_valid),
        .exit_code_o   (exit_code),
        .print_valid_o (print_valid),
        .print_char_o  (print_char)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        core_req   = 1'b1;
        core_addr  = addr;
        core_we    = we;
        core_be    = 4'hF;
        core_wdata = wdata;
    endtask

    task automatic clear_inputs();
        core_req   = 1'b0;
        core_addr  = '0;
        core_we    = 1'b0;
        core_be    = '0;
        core_wdata = '0;
        slv_gnt    = '0;
        slv_rvalid = '0;
        slv_rdata  = '0;
    endtask

    initial begin
        // ---------------- reset state, with busy inputs ----------------
        rst_n = 1'b0;
        drive_req(32'h1000_0000, 1'b1, 32'h0000_1234);
        slv_gnt    = 4'hF;
        slv_rvalid = 4'hF;
        slv_rdata  = {32'h4, 32'h3, 32'h2, 32'h1};
        #2;
        chk("rst_slv_req",     slv_req,     4'h0);
        chk("rst_gnt",         core_gnt,    1'b0);
        chk("rst_rvalid",      core_rvalid, 1'b0);
        chk("rst_rdata",       core_rdata,  32'h0);
        chk("rst_err",         core_err,    1'b0);
        chk("rst_slv_addr",    slv_addr,    32'h0);
        chk("rst_slv_we",      slv_we,      1'b0);
        chk("rst_slv_be",      slv_be,      4'h0);
        chk("rst_slv_wdata",   slv_wdata,   32'h0);
        chk("rst_exit_valid",  exit_valid,  1'b0);
        chk("rst_exit_code",   exit_code,   32'h0);
        chk("rst_print_valid", print_valid, 1'b0);
        chk("rst_print_char",  print_char,  8'h0);
        cyc();
        cyc();
        clear_inputs();
        rst_n = 1'b1;
        cyc();

        // ---------------- read from slave 1 ----------------
        drive_req(32'h2000_0010, 1'b0, 32'h0);
        slv_gnt = 4'b0010;
        #1;
        chk("t1_slv_req",  slv_req,  4'b0010);
        chk("t1_gnt",      core_gnt, 1'b1);
        chk("t1_slv_addr", slv_addr, 32'h2000_0010);
        chk("t1_slv_we",   slv_we,   1'b0);
        cyc();
        core_req     = 1'b0;
        slv_gnt      = '0;
        slv_rvalid   = 4'b0001;
        slv_rdata[0] = 32'hBAD0_0000;
        #1;
        chk("t1_other_rvalid_ignored", core_rvalid, 1'b0);
        chk("t1_other_rdata_zero",     core_rdata,  32'h0);
        chk("t1_cnt_1",                dut.cnt_q,   3'd1);
        cyc();
        slv_rvalid   = 4'b0010;
        slv_rdata[1] = 32'hCAFE_0001;
        #1;
        chk("t1_rvalid", core_rvalid, 1'b1);
        chk("t1_rdata",  core_rdata,  32'hCAFE_0001);
        chk("t1_err",    core_err,    1'b0);
        cyc();
        slv_rvalid = '0;
        #1;
        chk("t1_rvalid_drop", core_rvalid, 1'b0);
        chk("t1_cnt_0",       dut.cnt_q,   3'd0);

        // ---------------- fill to MAX_OUTST on slave 0 ----------------
        slv_gnt = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            drive_req(32'h1000_0000 + 32'(4 * k), 1'b0, 32'h0);
            #1;
            chk("t2_fill_gnt", core_gnt, 1'b1);
            cyc();
        end
        drive_req(32'h1000_0010, 1'b0, 32'h0);
        #1;
        chk("t2_full_gnt",     core_gnt,  1'b0);
        chk("t2_full_slv_req", slv_req,   4'b0000);
        chk("t2_cnt_4",        dut.cnt_q, 3'd4);
        cyc();
        #1;
        chk("t2_full_gnt_2",     core_gnt, 1'b0);
        chk("t2_full_slv_req_2", slv_req,  4'b0000);
        slv_rvalid   = 4'b0001;
        slv_rdata[0] = 32'h0000_A000;
        #1;
        chk("t2_rvalid",        core_rvalid, 1'b1);
        chk("t2_rdata",         core_rdata,  32'h0000_A000);
        chk("t2_gnt_on_rvalid", core_gnt,    1'b1);
        chk("t2_slv_req_on_rv", slv_req,     4'b0001);
        cyc();
        core_req = 1'b0;
        #1;
        chk("t2_cnt_still_4", dut.cnt_q, 3'd4);
        repeat (4) cyc();
        slv_rvalid = '0;
        #1;
        chk("t2_cnt_drained", dut.cnt_q, 3'd0);
        slv_rvalid = 4'b0001;
        #1;
        chk("t2_spurious_rvalid", core_rvalid, 1'b0);
        cyc();
        slv_rvalid = '0;
        #1;
        chk("t2_cnt_no_wrap", dut.cnt_q, 3'd0);

        // ---------------- target switch stalls until drained ----------------
        slv_gnt = 4'b0101;
        drive_req(32'h1000_0020, 1'b0, 32'h0);
        #1;
        chk("t3_gnt_s0", core_gnt, 1'b1);
        cyc();
        drive_req(32'h3000_0000, 1'b0, 32'h0);
        #1;
        chk("t3_stall_gnt",     core_gnt, 1'b0);
        chk("t3_stall_slv_req", slv_req,  4'b0000);
        cyc();
        #1;
        chk("t3_stall_gnt_2", core_gnt, 1'b0);
        slv_rvalid   = 4'b0001;
        slv_rdata[0] = 32'h1111_0000;
        #1;
        chk("t3_rvalid_s0",  core_rvalid, 1'b1);
        chk("t3_rdata_s0",   core_rdata,  32'h1111_0000);
        chk("t3_gnt_s2",     core_gnt,    1'b1);
        chk("t3_slv_req_s2", slv_req,     4'b0100);
        cyc();
        core_req     = 1'b0;
        slv_gnt      = '0;
        slv_rvalid   = 4'b0101;
        slv_rdata[2] = 32'hDEAD_0002;
        #1;
        chk("t3_rvalid_s2", core_rvalid, 1'b1);
        chk("t3_rdata_s2",  core_rdata,  32'hDEAD_0002);
        cyc();
        slv_rvalid = '0;
        #1;
        chk("t3_cnt_0", dut.cnt_q, 3'd0);

        // ---------------- unmapped address -> error ----------------
        drive_req(32'h0000_0004, 1'b0, 32'h0);
        #1;
        chk("t4_gnt",     core_gnt, 1'b1);
        chk("t4_slv_req", slv_req,  4'b0000);
        cyc();
        core_req = 1'b0;
        #1;
        chk("t4_rvalid", core_rvalid, 1'b1);
        chk("t4_err",    core_err,    1'b1);
        chk("t4_rdata",  core_rdata,  32'h0);
        cyc();
        #1;
        chk("t4_rvalid_drop", core_rvalid, 1'b0);
        chk("t4_err_drop",    core_err,    1'b0);

        // ---------------- MMIO writes ----------------
        drive_req(32'h8000_0000, 1'b1, 32'h0000_0004);
        #1;
        chk("t5_exit_gnt",         core_gnt,    1'b1);
        chk("t5_exit_valid",       exit_valid,  1'b1);
        chk("t5_exit_code",        exit_code,   32'h4);
        chk("t5_print_valid_idle", print_valid, 1'b0);
        chk("t5_slv_req_none",     slv_req,     4'b0000);
        cyc();
        drive_req(32'h8000_0004, 1'b1, 32'h0000_0041);
        #1;
        chk("t5_exit_valid_pulse", exit_valid,  1'b0);
        chk("t5_exit_code_held",   exit_code,   32'h4);
        chk("t5_wr_rvalid",        core_rvalid, 1'b1);
        chk("t5_wr_err",           core_err,    1'b0);
        chk("t5_print_valid",      print_valid, 1'b1);
        chk("t5_print_char",       print_char,  8'h41);
        cyc();
        drive_req(32'h8000_0008, 1'b1, 32'hFFFF_FFFF);
        #1;
        chk("t5_w8_exit_valid",  exit_valid,  1'b0);
        chk("t5_w8_print_valid", print_valid, 1'b0);
        chk("t5_w8_exit_code",   exit_code,   32'h4);
        cyc();
        core_req = 1'b0;
        core_we  = 1'b0;
        #1;
        chk("t5_w8_rvalid",     core_rvalid, 1'b1);
        chk("t5_exit_code_end", exit_code,   32'h4);
        cyc();
        #1;
        chk("t5_rvalid_drop", core_rvalid, 1'b0);
        chk("t5_cnt_0",       dut.cnt_q,   3'd0);

        // ---------------- reset with transactions outstanding ----------------
        slv_gnt = 4'b0001;
        drive_req(32'h1000_0000, 1'b0, 32'h0);
        repeat (3) cyc();
        chk("t6_cnt_3", dut.cnt_q, 3'd3);
        slv_rvalid = 4'b0001;
        rst_n      = 1'b0;
        #1;
        chk("t6_rst_slv_req",  slv_req,     4'b0000);
        chk("t6_rst_gnt",      core_gnt,    1'b0);
        chk("t6_rst_rvalid",   core_rvalid, 1'b0);
        chk("t6_rst_rdata",    core_rdata,  32'h0);
        chk("t6_rst_slv_addr", slv_addr,    32'h0);
        chk("t6_rst_cnt",      dut.cnt_q,   3'd0);
        cyc();
        rst_n      = 1'b1;
        slv_rvalid = '0;
        slv_gnt    = 4'b0010;
        drive_req(32'h2000_0000, 1'b0, 32'h0);
        #1;
        chk("t6_post_gnt",     core_gnt, 1'b1);
        chk("t6_post_slv_req", slv_req,  4'b0010);
        cyc();
        core_req     = 1'b0;
        slv_gnt      = '0;
        slv_rvalid   = 4'b0010;
        slv_rdata[1] = 32'h5555_0001;
        #1;
        chk("t6_post_rvalid", core_rvalid, 1'b1);
        chk("t6_post_rdata",  core_rdata,  32'h5555_0001);
        cyc();
        slv_rvalid = '0;

        // ---------------- MMIO cycle-counter reads ----------------
        rst_n = 1'b0;
        #1;
        cyc();
        rst_n = 1'b1;
        repeat (100) cyc();
        drive_req(32'h8000_0000, 1'b0, 32'h0);
        #1;
        chk("t7_cyc_gnt", core_gnt, 1'b1);
        cyc();
        drive_req(32'h8000_0008, 1'b0, 32'h0);
        #1;
        chk("t7_cyc_lo_rvalid", core_rvalid, 1'b1);
        chk("t7_cyc_lo",        core_rdata,  32'd100);
        chk("t7_cyc_lo_err",    core_err,    1'b0);
        cyc();
        drive_req(32'h8000_000C, 1'b0, 32'h0);
        #1;
        chk("t7_cyc_hi", core_rdata, 32'h0);
        cyc();
        drive_req(32'h8000_0004, 1'b0, 32'h0);
        #1;
        chk("t7_rd_c_rvalid", core_rvalid, 1'b1);
        chk("t7_rd_c",        core_rdata,  32'h0);
        cyc();
        core_req = 1'b0;
        #1;
        chk("t7_rd_4_rvalid", core_rvalid, 1'b1);
        chk("t7_rd_4",        core_rdata,  32'h0);
        chk("t7_rd_4_err",    core_err,    1'b0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
